// File: rtl/glm_pkg.sv
// Shared definitions for the GLM 1/8-scan panel sequencer and the frame-buffer writer.
// Pixel words carry one 6-bit {R1,G1,B1,R2,G2,B2} slice per bit plane, plane 0 in the LSBs.
package glm_pkg;

  localparam int ROWS  = 8;
  localparam int ROW_W = 3;
  localparam int PIX_W = 6;

  // Bit positions inside one plane slice; the frame-buffer writer packs with these.
  localparam int BIT_R1 = 5;
  localparam int BIT_G1 = 4;
  localparam int BIT_B1 = 3;
  localparam int BIT_R2 = 2;
  localparam int BIT_G2 = 1;
  localparam int BIT_B2 = 0;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    LATCH,
    GUARD,
    DISPLAY
  } state_t;

  function automatic int plane_lsb(input int p);
    return p * PIX_W;
  endfunction

endpackage

// File: rtl/glm_scan_ctrl_if.sv
// Frame-buffer read port plus panel connector pins; master is the scan sequencer,
// slave is the RAM/panel side.
interface glm_scan_ctrl_if import glm_pkg::*; #(
  parameter int COLS   = 32,
  parameter int PLANES = 4
);
  localparam int AW = ROW_W + $clog2(COLS);

  logic [AW-1:0]           fb_addr;
  logic [PIX_W*PLANES-1:0] fb_rdata;
  logic GLM_R1, GLM_G1, GLM_B1;
  logic GLM_R2, GLM_G2, GLM_B2;
  logic GLM_A, GLM_B, GLM_C;
  logic GLM_OE, GLM_LAT, GLM_CLK;

  modport master (
    output fb_addr,
    input  fb_rdata,
    output GLM_R1, GLM_G1, GLM_B1, GLM_R2, GLM_G2, GLM_B2,
    output GLM_A, GLM_B, GLM_C, GLM_OE, GLM_LAT, GLM_CLK
  );

  modport slave (
    input  fb_addr,
    output fb_rdata,
    input  GLM_R1, GLM_G1, GLM_B1, GLM_R2, GLM_G2, GLM_B2,
    input  GLM_A, GLM_B, GLM_C, GLM_OE, GLM_LAT, GLM_CLK
  );

endinterface

// File: rtl/glm_shift_gen.sv
// Column counter and GLM_CLK divider for one row shift; start launches COLS columns,
// done flags the final cycle so the caller can move on at the same edge.
module glm_shift_gen import glm_pkg::*; #(
  parameter int COLS    = 32,
  parameter int CLK_DIV = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    glm_clk,
  output logic [$clog2(COLS)-1:0] col,
  output logic                    load_px,
  output logic                    addr_adv,
  output logic                    last_col,
  output logic                    done
);

  localparam int CW   = $clog2(COLS);
  localparam int PH_W = $clog2(2 * CLK_DIV);
  localparam logic [PH_W-1:0] PH_RISE = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_ADR  = PH_W'(2 * CLK_DIV - 2);
  localparam logic [PH_W-1:0] PH_END  = PH_W'(2 * CLK_DIV - 1);

  logic            active;
  logic [PH_W-1:0] ph;

  // Address for the next column goes out one cycle before its phase 0, so the RAM
  // word is ready at phase 0 and the pins settle at phase 1, CLK_DIV-1 cycles before the rise.
  assign load_px  = active && (ph == '0);
  assign addr_adv = active && (ph == PH_ADR);
  assign last_col = (col == CW'(COLS - 1));
  assign done     = active && (ph == PH_END) && last_col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      ph      <= '0;
      col     <= '0;
      glm_clk <= 1'b0;
    end else if (start) begin
      active  <= 1'b1;
      ph      <= '0;
      col     <= '0;
      glm_clk <= 1'b0;
    end else if (active) begin
      if (ph == PH_RISE) glm_clk <= 1'b1;
      if (ph == PH_END) begin
        glm_clk <= 1'b0;
        ph      <= '0;
        col     <= col + CW'(1);
        if (last_col) active <= 1'b0;
      end else begin
        ph <= ph + PH_W'(1);
      end
    end
  end

endmodule

// File: rtl/glm_scan_ctrl.sv
// BCM scan sequencer: shift a row pair per bit plane, latch, blank, then light it for
// OE_BASE<<plane cycles. Frames always run to completion once started.
module glm_scan_ctrl import glm_pkg::*; #(
  parameter int COLS      = 32,
  parameter int CLK_DIV   = 2,
  parameter int PLANES    = 4,
  parameter int OE_BASE   = 64,
  parameter int BLANK_CYC = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  glm_scan_ctrl_if.master pnl,
  output logic            busy,
  output logic            frame_done
);

  localparam int CW     = $clog2(COLS);
  localparam int PW     = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int OE_MAX = OE_BASE << (PLANES - 1);
  localparam int TW     = (OE_MAX > 1) ? $clog2(OE_MAX) : 1;
  localparam int GW     = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

  state_t                  state;
  logic [ROW_W-1:0]        row;
  logic [PW-1:0]           plane;
  logic [TW-1:0]           tmr;
  logic [GW-1:0]           gcnt;
  logic [PIX_W-1:0]        pix;
  logic [ROW_W-1:0]        abc;
  logic                    oe;
  logic                    lat;
  logic [ROW_W+CW-1:0]     fb_addr;

  logic                    sg_clk;
  logic [CW-1:0]           sg_col;
  logic                    sg_load, sg_adv, sg_last, sg_done;
  logic                    start, last_plane, frame_end, disp_end;
  logic [ROW_W-1:0]        next_row;

  function automatic logic [TW-1:0] disp_last(input logic [PW-1:0] p);
    return TW'((OE_BASE << p) - 1);
  endfunction

  assign last_plane = (plane == PW'(PLANES - 1));
  assign frame_end  = last_plane && (row == ROW_W'(ROWS - 1));
  assign disp_end   = (state == DISPLAY) && (tmr == disp_last(plane));
  assign next_row   = last_plane ? row + ROW_W'(1) : row;
  assign start      = ((state == IDLE) && enable) || (disp_end && (!frame_end || enable));

  glm_shift_gen #(.COLS(COLS), .CLK_DIV(CLK_DIV)) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .glm_clk  (sg_clk),
    .col      (sg_col),
    .load_px  (sg_load),
    .addr_adv (sg_adv),
    .last_col (sg_last),
    .done     (sg_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      row        <= '0;
      plane      <= '0;
      tmr        <= '0;
      gcnt       <= '0;
      pix        <= '0;
      abc        <= '0;
      oe         <= 1'b1;
      lat        <= 1'b0;
      fb_addr    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (sg_load) pix <= pnl.fb_rdata[plane_lsb(int'(plane)) +: PIX_W];
      // After the last column the address is parked on column 0 of the next shift.
      if (sg_adv) fb_addr <= sg_last ? {next_row, CW'(0)} : {row, sg_col + CW'(1)};
      case (state)
        IDLE: begin
          oe <= 1'b1;
          if (enable) begin
            state <= SHIFT;
            busy  <= 1'b1;
            row   <= '0;
            plane <= '0;
          end
        end
        SHIFT: if (sg_done) begin
          state <= LATCH;
          lat   <= 1'b1;
          abc   <= row;
        end
        LATCH: begin
          state <= GUARD;
          lat   <= 1'b0;
          gcnt  <= '0;
        end
        GUARD: begin
          if (gcnt == GW'(BLANK_CYC - 1)) begin
            state <= DISPLAY;
            oe    <= 1'b0;
            tmr   <= '0;
          end else begin
            gcnt <= gcnt + GW'(1);
          end
        end
        DISPLAY: begin
          if (disp_end) begin
            oe    <= 1'b1;
            plane <= last_plane ? '0 : plane + PW'(1);
            row   <= next_row;
            state <= SHIFT;
            if (frame_end) begin
              frame_done <= 1'b1;
              if (!enable) begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pnl.fb_addr = fb_addr;
  assign pnl.GLM_R1  = pix[BIT_R1];
  assign pnl.GLM_G1  = pix[BIT_G1];
  assign pnl.GLM_B1  = pix[BIT_B1];
  assign pnl.GLM_R2  = pix[BIT_R2];
  assign pnl.GLM_G2  = pix[BIT_G2];
  assign pnl.GLM_B2  = pix[BIT_B2];
  assign pnl.GLM_A   = abc[0];
  assign pnl.GLM_B   = abc[1];
  assign pnl.GLM_C   = abc[2];
  assign pnl.GLM_OE  = oe;
  assign pnl.GLM_LAT = lat;
  assign pnl.GLM_CLK = sg_clk;

endmodule

// File: tb/tb_glm_scan_ctrl.sv
// Directed bench for glm_scan_ctrl: panel-side event recorder plus linear stimulus
// with immediate-assertion checks against hand-derived timing.
module tb_glm_scan_ctrl;
  import glm_pkg::*;

  localparam int COLS = 4, CLK_DIV = 2, PLANES = 2, OE_BASE = 8, BLANK_CYC = 2;

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic busy, frame_done;

  glm_scan_ctrl_if #(.COLS(COLS), .PLANES(PLANES)) pi ();

  glm_scan_ctrl #(
    .COLS(COLS), .CLK_DIV(CLK_DIV), .PLANES(PLANES),
    .OE_BASE(OE_BASE), .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .pnl(pi.master), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [11:0] mem [0:31];
  always @(posedge clk) pi.fb_rdata <= mem[pi.fb_addr];

  // Panel-side recorder, sampled on the falling edge.
  int cyc = 0, rises = 0, rise_row = 0, oe_len = 0, addr_chg = 0, lat_oe_bad = 0;
  logic pclk = 1'b0, pbusy = 1'b0;
  logic [4:0] paddr = '0;
  logic [5:0] cap [0:3];
  int lat_cyc[$], lat_abc[$], lat_rises[$], oe_run[$], oe_start[$], fd_cyc[$], busy_rise[$];
  logic [23:0] lat_cap[$];
  logic [5:0] pins;
  assign pins = {pi.GLM_R1, pi.GLM_G1, pi.GLM_B1, pi.GLM_R2, pi.GLM_G2, pi.GLM_B2};

  always @(negedge clk) begin
    cyc++;
    if (pi.GLM_CLK && !pclk) begin
      rises++;
      if (rise_row < 4) cap[rise_row] = pins;
      rise_row++;
    end
    pclk = pi.GLM_CLK;
    if (pi.GLM_LAT) begin
      lat_cyc.push_back(cyc);
      lat_abc.push_back(int'({pi.GLM_C, pi.GLM_B, pi.GLM_A}));
      lat_rises.push_back(rises);
      lat_cap.push_back({cap[0], cap[1], cap[2], cap[3]});
      rise_row = 0;
      if (!pi.GLM_OE) lat_oe_bad++;
    end
    if (!pi.GLM_OE) begin
      if (oe_len == 0) oe_start.push_back(cyc);
      oe_len++;
    end else if (oe_len > 0) begin
      oe_run.push_back(oe_len);
      oe_len = 0;
    end
    if (frame_done) fd_cyc.push_back(cyc);
    if (busy && !pbusy) busy_rise.push_back(cyc);
    pbusy = busy;
    if (pi.fb_addr !== paddr) addr_chg++;
    paddr = pi.fb_addr;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int b, a0, nl, nr, nb;
    for (int i = 0; i < 32; i++) mem[i] = {6'(i * 3 + 1), 6'(i * 5 + 7)};
    mem[{3'd3, 2'd2}] = 12'b101010_010101;

    // 1: reset values, then idle with enable low
    repeat (3) tick();
    check("rst_oe", pi.GLM_OE, 1);
    check("rst_clk", pi.GLM_CLK, 0);
    check("rst_lat", pi.GLM_LAT, 0);
    check("rst_busy", busy, 0);
    check("rst_fd", frame_done, 0);
    check("rst_addr", pi.fb_addr, 0);
    check("rst_abc", {pi.GLM_C, pi.GLM_B, pi.GLM_A}, 0);
    check("rst_pins", pins, 0);
    rst_n = 1'b1;
    a0 = addr_chg;
    repeat (50) tick();
    check("idle_addr_chg", addr_chg, a0);
    check("idle_rises", rises, 0);
    check("idle_lats", lat_cyc.size(), 0);
    check("idle_busy", busy, 0);
    check("idle_oe", pi.GLM_OE, 1);

    // 2-4: one full frame
    enable = 1'b1;
    for (int i = 0; i < 600 && fd_cyc.size() < 1; i++) tick();
    check("f1_done_seen", fd_cyc.size(), 1);
    check("f1_busy_rise", busy_rise.size(), 1);
    b = busy_rise[0];
    check("shift_len", lat_cyc[0] - b, 16);
    check("shift_rises", lat_rises[0], 4);
    check("guard_len", oe_start[0] - lat_cyc[0], 3);
    check("oe_plane0", oe_run[0], 8);
    check("row_pair_len", lat_cyc[1] - lat_cyc[0], 27);
    check("shift_rises_p1", lat_rises[1] - lat_rises[0], 4);
    check("oe_plane1", oe_run[1], 16);
    check("frame_len", fd_cyc[0] - b, 496);
    check("f1_lat_count", lat_cyc.size(), 16);
    for (int k = 0; k < 16; k++) check($sformatf("f1_row_%0d", k), lat_abc[k], k / 2);
    check("row0_col0_p0", lat_cap[0][23:18], mem[0][5:0]);
    check("row3_abc", lat_abc[6], 3);
    check("row3_col2_p0", lat_cap[6][11:6], 6'b010101);
    check("row3_col2_p1", lat_cap[7][11:6], 6'b101010);

    // 5: drop enable during row 4 of the second frame
    for (int i = 0; i < 600 && lat_cyc.size() < 25; i++) tick();
    check("f2_row4_seen", lat_abc[24], 4);
    enable = 1'b0;
    for (int i = 0; i < 600 && fd_cyc.size() < 2; i++) tick();
    check("f2_done_seen", fd_cyc.size(), 2);
    check("f2_frame_len", fd_cyc[1] - fd_cyc[0], 496);
    check("f2_fd_pulse", frame_done, 1);
    check("f2_busy_off", busy, 0);
    check("f2_oe_off", pi.GLM_OE, 1);
    check("f2_lat_count", lat_cyc.size(), 32);
    for (int k = 24; k < 32; k++) check($sformatf("f2_row_%0d", k), lat_abc[k], (k - 16) / 2);
    repeat (100) tick();
    check("idle2_lats", lat_cyc.size(), 32);
    check("idle2_busy", busy, 0);
    check("idle2_oe", pi.GLM_OE, 1);
    check("idle2_fd", fd_cyc.size(), 2);
    check("idle2_clk", pi.GLM_CLK, 0);

    // 6: asynchronous reset while row 5 is on display
    enable = 1'b1;
    for (int i = 0; i < 600 && lat_cyc.size() < 43; i++) tick();
    for (int i = 0; i < 20 && pi.GLM_OE !== 1'b0; i++) tick();
    check("pre_rst_oe", pi.GLM_OE, 0);
    check("pre_rst_abc", {pi.GLM_C, pi.GLM_B, pi.GLM_A}, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_oe", pi.GLM_OE, 1);
    check("arst_lat", pi.GLM_LAT, 0);
    check("arst_clk", pi.GLM_CLK, 0);
    check("arst_busy", busy, 0);
    check("arst_addr", pi.fb_addr, 0);
    check("arst_abc", {pi.GLM_C, pi.GLM_B, pi.GLM_A}, 0);
    check("arst_pins", pins, 0);
    check("arst_fd", frame_done, 0);
    tick();
    rst_n = 1'b1;
    nl = lat_cyc.size();
    nr = oe_run.size();
    nb = busy_rise.size();
    for (int i = 0; i < 100 && lat_cyc.size() <= nl; i++) tick();
    check("restart_lat_seen", lat_cyc.size(), nl + 1);
    check("restart_row", lat_abc[nl], 0);
    check("restart_shift_len", lat_cyc[nl] - busy_rise[nb], 16);
    for (int i = 0; i < 100 && oe_run.size() <= nr; i++) tick();
    check("restart_oe_p0", oe_run[nr], 8);
    check("lat_never_with_oe", lat_oe_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
